// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and constants for the UART transmit arbiter
`ifndef UART_DATA_SIZE
`define UART_DATA_SIZE 8
`endif
package uart_tx_arbiter_pkg;
  localparam int UART_ARB_DATA_W = `UART_DATA_SIZE;
  localparam logic [UART_ARB_DATA_W-1:0] UART_ARB_EOP_DEFAULT = 8'h0A;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} type_uart_arb_state_e;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin first-set-bit finder starting at ptr_i with wrap
module uart_rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  // Scan from farthest to nearest so the closest set bit at or after ptr_i wins
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = W'((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer; UART_ARB_LOCK_EN adds packet lock
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter logic [UART_ARB_DATA_W-1:0] EOP_BYTE = UART_ARB_EOP_DEFAULT,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ*UART_ARB_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                   req_ack_o,
  output logic [UART_ARB_DATA_W-1:0]           tx_data_o,
  output logic                                 tx_valid_o,
  input  logic                                 tx_ready_i,
  output logic [REQ_ID_W-1:0]                  grant_id_o,
  output logic                                 busy_o
);
  type_uart_arb_state_e state_q;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] ack_q;
  logic [UART_ARB_DATA_W-1:0] tx_data_q;
  logic [UART_ARB_DATA_W-1:0] pick_data;
  logic [REQ_ID_W-1:0] pick_idx;
  logic [REQ_ID_W-1:0] grant_q;
  logic [REQ_ID_W-1:0] rr_ptr_q;
  logic [REQ_ID_W-1:0] rr_ptr_d;
  logic pick_v;
  logic grant;
  logic tx_valid_q;
  logic busy_q;

  if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535 ||
      $bits(EOP_BYTE) != UART_ARB_DATA_W) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  uart_rr_picker #(.N(NUM_REQ), .W(REQ_ID_W)) u_pick (
    .req_i  (cand),
    .ptr_i  (rr_ptr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  assign pick_data = req_data_i[int'(pick_idx)*UART_ARB_DATA_W +: UART_ARB_DATA_W];
  assign grant = (state_q == IDLE) && tx_ready_i && pick_v;
  assign rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_LOCK_EN
  logic lock_q;
  logic [REQ_ID_W-1:0] lock_id_q;
  logic [15:0] idle_cnt_q;

  // While locked only the lock owner may compete for the serializer
  always_comb begin
    cand = lock_q ? req_valid_i & (NUM_REQ'(1) << lock_id_q) : req_valid_i;
  end

  // Lock follows each grant until EOP is sent or the owner stays silent too long
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      lock_id_q <= '0;
      idle_cnt_q <= '0;
    end else if (grant) begin
      lock_q <= pick_data != EOP_BYTE;
      lock_id_q <= pick_idx;
      idle_cnt_q <= '0;
    end else if (state_q == IDLE && lock_q && !req_valid_i[lock_id_q]) begin
      lock_q <= idle_cnt_q != 16'(LOCK_TIMEOUT - 1);
      idle_cnt_q <= (idle_cnt_q == 16'(LOCK_TIMEOUT - 1)) ? '0 : idle_cnt_q + 1'b1;
    end
  end
`else
  assign cand = req_valid_i;
`endif

  // Grant and valid/ready handshake sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      ack_q <= '0;
      grant_q <= '0;
      busy_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE:
          if (grant) begin
            tx_data_q <= pick_data;
            grant_q <= pick_idx;
            ack_q <= NUM_REQ'(1) << pick_idx;
            tx_valid_q <= 1'b1;
            busy_q <= 1'b1;
            state_q <= SEND;
          end
        SEND: state_q <= WAIT_BUSY;
        WAIT_BUSY: if (!tx_ready_i) state_q <= WAIT_DONE;
        WAIT_DONE:
          if (tx_ready_i) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack_o = ack_q;
  assign tx_data_o = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign grant_id_o = grant_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (lock cases with UART_ARB_LOCK_EN)
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0] req_ack_o;
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i;
  logic [0:0] grant_id_o;
  logic busy_o;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, tx_data_o, 0);
    chk({tag, "_valid"}, tx_valid_o, 0);
    chk({tag, "_ack"}, req_ack_o, 0);
    chk({tag, "_gid"}, grant_id_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic chk_grant(input string tag, input logic [0:0] id, input logic [7:0] data);
    chk({tag, "_ack"}, req_ack_o, 2'b01 << id);
    chk({tag, "_valid"}, tx_valid_o, 1);
    chk({tag, "_data"}, tx_data_o, data);
    chk({tag, "_gid"}, grant_id_o, id);
  endtask

  // SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE with a serializer busy for one cycle
  task automatic finish();
    tick();
    tx_ready_i = 1'b0;
    tick();
    tx_ready_i = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    tx_ready_i = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    req_valid_i = 2'b01;
    req_data_i = 16'h0041;
    tick();
    chk_grant("single", 0, 8'h41);
    chk("single_busy", busy_o, 1);
    req_valid_i = '0;
    tick();
    chk("single_pulse", tx_valid_o, 0);
    chk("single_ackpulse", req_ack_o, 0);
    tx_ready_i = 1'b0;
    tick();
    chk("single_busy_wd", busy_o, 1);
    tx_ready_i = 1'b1;
    tick();
    chk("single_idle", busy_o, 0);
    chk("single_hold", tx_data_o, 8'h41);
    tick();
    chk("single_noregrant", req_ack_o, 0);
    do_reset();
    req_valid_i = 2'b11;
    req_data_i = 16'h3130;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant($sformatf("rr%0d", i), 1'(i % 2), 8'h30 + 8'(i % 2));
      finish();
    end
    req_valid_i = 2'b01;
    req_data_i = 16'h0055;
    tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_ack%0d", i), req_ack_o, 0);
      chk($sformatf("stall_valid%0d", i), tx_valid_o, 0);
    end
    tx_ready_i = 1'b1;
    tick();
    chk_grant("stall_go", 0, 8'h55);
    req_valid_i = 2'b10;
    req_data_i = 16'h6600;
    finish();
    tick();
    chk_grant("pre_rst", 1, 8'h66);
    req_valid_i = '0;
    tick();
    tx_ready_i = 1'b0;
    tick();
    chk("pre_rst_wd", busy_o, 1);
    rst_n = 1'b0;
    tick();
    chk_zero("midrst");
    rst_n = 1'b1;
    req_valid_i = 2'b11;
    req_data_i = 16'h6261;
    tick();
    chk("midrst_waitready", req_ack_o, 0);
    tx_ready_i = 1'b1;
    tick();
    chk_grant("post_rst", 0, 8'h61);
    req_valid_i = 2'b01;
    req_data_i = 16'h6263;
    finish();
    tick();
    chk_grant("b2b", 0, 8'h63);
    req_valid_i = '0;
    finish();
`ifdef UART_ARB_LOCK_EN
    do_reset();
    req_valid_i = 2'b11;
    req_data_i = 16'h7748;
    tick();
    chk_grant("lk48", 0, 8'h48);
    req_data_i = 16'h7749;
    finish();
    tick();
    chk_grant("lk49", 0, 8'h49);
    req_data_i = 16'h770A;
    finish();
    tick();
    chk_grant("lk0a", 0, 8'h0A);
    req_valid_i = 2'b10;
    finish();
    tick();
    chk_grant("lk_rel", 1, 8'h77);
    req_valid_i = '0;
    finish();
    do_reset();
    req_valid_i = 2'b11;
    req_data_i = 16'h7748;
    tick();
    chk_grant("to48", 0, 8'h48);
    req_valid_i = 2'b10;
    finish();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), req_ack_o, 0);
    end
    tick();
    chk_grant("to_rel", 1, 8'h77);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers (for example core console and debug module).
- Round-robin arbitration, one byte per grant.
- Sequences the uart_tx valid_i/ready_o handshake: a one-cycle valid pulse while the serializer is idle, then tracks busy and done.
- Sits between the requesters and the uart_tx_module instance inside the UART peripheral.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REQ_ID_W, $clog2(NUM_REQ), grant index width.
- EOP_BYTE, 8'h0A, end-of-packet byte; used only with the optional lock feature.
- LOCK_TIMEOUT, 1024, idle cycles before a held lock is dropped; used only with the optional lock feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  NUM_REQ  requester i has a byte pending
- req_data_i  in  NUM_REQ*8  byte of requester i, bits [8i+7:8i]
- req_ack_o  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- tx_data_o  out  8  to uart_tx tx_data_i
- tx_valid_o  out  1  to uart_tx valid_i
- tx_ready_i  in  1  from uart_tx ready_o (high = idle)
- grant_id_o  out  REQ_ID_W  index of the last/current granted requester
- busy_o  out  1  a byte is in flight

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rr_ptr=0, and every output is 0 (tx_data_o=0, tx_valid_o=0, req_ack_o=0, grant_id_o=0, busy_o=0).
- Reset asserted mid-transfer: the FSM abandons the byte. The serializer finishes on its own. The arbiter restarts only from IDLE and waits for tx_ready_i=1 before the next grant.
- FSM IDLE: if tx_ready_i=1 and any req_valid_i is set, the winner is the first set bit scanning from rr_ptr upward with wrap. The arbiter then:
  - registers the winner's byte into tx_data_o,
  - sets grant_id_o to the winner,
  - pulses req_ack_o[winner] in the same cycle,
  - goes to SEND.
  If tx_ready_i=0, it stays in IDLE.
- SEND: tx_valid_o=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_ready_i=0, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_ready_i=1, then go to IDLE and set rr_ptr = grant+1 mod NUM_REQ.
- Latency: grant to tx_valid_o is 1 cycle. The next grant comes no earlier than 1 cycle after tx_ready_i returns high.
- busy_o=1 in SEND, WAIT_BUSY and WAIT_DONE.
- tx_data_o is stable from SEND until the next grant.
- Requester contract: hold data stable while valid. After the ack, the byte is consumed; the requester may present the next byte or deassert valid.
- Simultaneous requests: round robin, so no requester waits more than NUM_REQ-1 grants.
- A single requester can be granted back-to-back.
- A requester deasserting valid before its grant is simply skipped; no error.
- NUM_REQ=1: rr_ptr stays at 0.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined: after granting requester i, the lock holds grant on i until a byte equal to EOP_BYTE has been sent. Other requesters are ignored while locked.
  - A 16-bit idle counter counts IDLE cycles in which the locked requester has req_valid_i low.
  - The counter resets on every grant.
  - When it reaches LOCK_TIMEOUT, the lock clears and round robin resumes from i+1.
  - The lock also clears on reset.
- Not defined: pure per-byte round robin; no lock register and no counter are built.

Decomposition:
- Shared package holds:
  - type_uart_arb_state_e (IDLE, SEND, WAIT_BUSY, WAIT_DONE),
  - the UART_ARB_EOP_DEFAULT constant,
  - reuse of `UART_DATA_SIZE for the byte width.
- Natural sub-module: uart_rr_picker, a combinational round-robin first-set-bit finder taking a request vector and pointer and returning valid plus index.

Test Plan:
- Single request: req_valid_i=01, data0=8'h41, tx_ready_i=1 → req_ack_o=01 next edge; tx_valid_o=1 for one cycle with tx_data_o=8'h41; busy_o returns to 0 after tx_ready_i falls then rises.
- Contention: both valid, data0=8'h30, data1=8'h31, held for 4 bytes → tx_data_o sequence 30,31,30,31; grant_id_o alternates 0,1,0,1.
- Serializer busy: tx_ready_i=0 in IDLE with a request → no ack and no tx_valid_o until tx_ready_i=1.
- Reset mid-transfer: rst_n low during WAIT_DONE → next edge all outputs 0 and state IDLE; the following request is granted to requester 0 first.
- With UART_ARB_LOCK_EN, lock to EOP: req0 sends 48,49,0A while req1 stays valid → req1 gets no ack until after 0A; then grant_id_o=1.
- With UART_ARB_LOCK_EN, LOCK_TIMEOUT=8: req0 sends 48 then drops valid, req1 valid → req1 is acked exactly after 8 idle cycles.
